// File: rtl/des_key_scheduler_pkg.sv
// rtl/des_key_scheduler_pkg.sv - shared constants, types and rotate schedule for the DES key scheduler
package des_key_scheduler_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam int RND_W      = 5;

  localparam logic [RND_W-1:0] LAST_ROUND   = RND_W'(NUM_ROUNDS);
  localparam logic [RND_W-1:0] SUB_IDX_BASE = RND_W'(NUM_ROUNDS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    ROT_LEFT  = 1'b0,
    ROT_RIGHT = 1'b1
  } rot_dir_t;

  // SHIFT_SCHED {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}, indexed by DES round 1..16
  function automatic logic [1:0] shift_sched(input logic [RND_W-1:0] rnd);
    logic [1:0] amt;
    case (rnd)
      5'd1, 5'd2, 5'd9, 5'd16: amt = 2'd1;
      default:                 amt = 2'd2;
    endcase
    return amt;
  endfunction

endpackage

// File: rtl/des_key_rotator.sv
// rtl/des_key_rotator.sv - rotates the 28-bit C and D halves left or right by 1 or 2
module des_key_rotator
  import des_key_scheduler_pkg::*;
(
  input  logic [27:0] c_in,
  input  logic [27:0] d_in,
  input  logic [1:0]  amt,
  input  rot_dir_t    dir,
  output logic [27:0] c_out,
  output logic [27:0] d_out
);

  // Bit 1 of a half is the MSB here, so a DES left rotate moves bits toward [27]
  always_comb begin
    c_out = c_in;
    d_out = d_in;
    if (dir == ROT_LEFT) begin
      if (amt == 2'd2) begin
        c_out = {c_in[25:0], c_in[27:26]};
        d_out = {d_in[25:0], d_in[27:26]};
      end else begin
        c_out = {c_in[26:0], c_in[27]};
        d_out = {d_in[26:0], d_in[27]};
      end
    end else begin
      if (amt == 2'd2) begin
        c_out = {c_in[1:0], c_in[27:2]};
        d_out = {d_in[1:0], d_in[27:2]};
      end else begin
        c_out = {c_in[0], c_in[27:1]};
        d_out = {d_in[0], d_in[27:1]};
      end
    end
  end

endmodule

// File: rtl/des_pc1.sv
// rtl/des_pc1.sv - DES permuted choice 1: 64-bit key to 56-bit C/D (parity bits dropped)
module des_pc1 (
  input  logic [63:0] key,
  output logic [55:0] cd
);

  // Entry i names the key bit (1 = MSB) that lands in output bit i+1 (1 = MSB)
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  for (genvar i = 0; i < 56; i++) begin : g_bit
    assign cd[55-i] = key[64-PC1_TBL[i]];
  end

endmodule

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - DES permuted choice 2: 56-bit C/D to 48-bit round subkey
module des_pc2 (
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  // Entry i names the C/D bit (1 = MSB of C) that lands in subkey bit i+1 (1 = MSB)
  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign subkey[47-i] = cd[56-PC2_TBL[i]];
  end

endmodule

// File: rtl/des_key_scheduler.sv
// rtl/des_key_scheduler.sv - iterative DES round-key scheduler, one subkey per handshake
module des_key_scheduler
  import des_key_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        abort,
  output logic [47:0] subkey,
  output logic [4:0]  subkey_idx,
  output logic        subkey_last,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        busy
);

  state_t           state_q, state_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [55:0]      cd_q, cd_d;
  logic             mode_q, mode_d;

  logic [55:0]      pc1_key;
  logic [55:0]      rot_in;
  logic [55:0]      rot_out;
  logic [1:0]       rot_amt;
  rot_dir_t         rot_dir;

  des_pc1 u_pc1 (
    .key (key_in),
    .cd  (pc1_key)
  );

  des_pc2 u_pc2 (
    .cd     (cd_q),
    .subkey (subkey)
  );

  des_key_rotator u_rot (
    .c_in  (rot_in[55:28]),
    .d_in  (rot_in[27:0]),
    .amt   (rot_amt),
    .dir   (rot_dir),
    .c_out (rot_out[55:28]),
    .d_out (rot_out[27:0])
  );

  // One rotator serves both jobs: rotl1 of the fresh PC1 value in IDLE, the next-round step in RUN
  always_comb begin
    rot_in  = pc1_key;
    rot_amt = 2'd1;
    rot_dir = ROT_LEFT;
    if (state_q == RUN) begin
      rot_in = cd_q;
      if (mode_q) begin
        rot_amt = shift_sched(SUB_IDX_BASE - round_q);
        rot_dir = ROT_RIGHT;
      end else begin
        rot_amt = shift_sched(round_q + 5'd1);
      end
    end
  end

  // Next state: key capture in IDLE, advance on handshake in RUN; abort beats the final handshake
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    cd_d    = cd_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d = RUN;
          round_d = 5'd1;
          mode_d  = decrypt;
          // Decrypt starts from C16/D16, which equals PC1 since the shifts total 28
          cd_d    = decrypt ? pc1_key : rot_out;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          round_d = '0;
        end else if (subkey_ready) begin
          if (round_q == LAST_ROUND) begin
            state_d = IDLE;
            round_d = '0;
          end else begin
            round_d = round_q + 5'd1;
            cd_d    = rot_out;
          end
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
      end
    endcase
  end

  // State, round counter, C/D halves and latched mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= '0;
      cd_q    <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cd_q    <= cd_d;
      mode_q  <= mode_d;
    end
  end

  assign key_ready    = (state_q == IDLE);
  assign subkey_valid = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign subkey_idx   = (state_q == RUN) ? (mode_q ? (SUB_IDX_BASE - round_q) : round_q) : '0;
  assign subkey_last  = (state_q == RUN) && (round_q == LAST_ROUND);

endmodule

// File: tb/tb_des_key_scheduler.sv
// tb/tb_des_key_scheduler.sv - self-checking bench for des_key_scheduler
module tb_des_key_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] key_in;
  logic        decrypt;
  logic        key_valid;
  logic        key_ready;
  logic        abort;
  logic [47:0] subkey;
  logic [4:0]  subkey_idx;
  logic        subkey_last;
  logic        subkey_valid;
  logic        subkey_ready;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [47:0] sk;
    logic [4:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb[$];

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int ROT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .abort        (abort),
    .subkey       (subkey),
    .subkey_idx   (subkey_idx),
    .subkey_last  (subkey_last),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference DES subkey Kn computed from scratch with cumulative left rotates
  function automatic logic [47:0] model_subkey(input logic [63:0] key, input int n);
    logic [1:64] k;
    logic [1:28] c;
    logic [1:28] d;
    logic [1:48] sk;
    k = key;
    for (int j = 1; j <= 28; j++) begin
      c[j] = k[PC1_T[j-1]];
      d[j] = k[PC1_T[j+27]];
    end
    for (int r = 1; r <= n; r++) begin
      for (int s = 0; s < ROT_T[r-1]; s++) begin
        c = {c[2:28], c[1]};
        d = {d[2:28], d[1]};
      end
    end
    for (int j = 1; j <= 48; j++) begin
      if (PC2_T[j-1] <= 28) sk[j] = c[PC2_T[j-1]];
      else                  sk[j] = d[PC2_T[j-1]-28];
    end
    return sk;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push_schedule(input logic [63:0] key, input logic dec);
    exp_t e;
    for (int i = 1; i <= 16; i++) begin
      e.idx  = dec ? 5'(17 - i) : 5'(i);
      e.sk   = model_subkey(key, int'(e.idx));
      e.last = (i == 16);
      sb.push_back(e);
    end
  endtask

  // Called at a falling edge: check outputs against the model, drive inputs, advance the model, step one cycle
  task automatic cycle(input logic kv, input logic [63:0] k, input logic dec,
                       input logic rdy, input logic ab);
    logic running;
    running = (sb.size() != 0);
    check("key_ready", key_ready, !running);
    check("subkey_valid", subkey_valid, running);
    check("busy", busy, running);
    if (running) begin
      check("subkey", subkey, sb[0].sk);
      check("subkey_idx", subkey_idx, sb[0].idx);
      check("subkey_last", subkey_last, sb[0].last);
    end
    key_valid    = kv;
    key_in       = k;
    decrypt      = dec;
    subkey_ready = rdy;
    abort        = ab;
    if (running) begin
      if (ab) sb.delete();
      else if (rdy) void'(sb.pop_front());
    end else if (kv) begin
      push_schedule(k, dec);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    logic [63:0] rk;
    reset        = 1'b1;
    key_in       = '0;
    decrypt      = 1'b0;
    key_valid    = 1'b0;
    abort        = 1'b0;
    subkey_ready = 1'b0;

    @(negedge clk);
    check("rst_key_ready", key_ready, 1'b1);
    check("rst_subkey_valid", subkey_valid, 1'b0);
    check("rst_subkey", subkey, 48'h0);
    check("rst_subkey_idx", subkey_idx, 5'd0);
    check("rst_subkey_last", subkey_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Encrypt order on the reference key, ready always high
    cycle(1'b1, KEY_A, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        check("enc_k1_literal", subkey, 48'h1B02EFFC7072);
        check("enc_k1_idx", subkey_idx, 5'd1);
      end
      if (i == 15) begin
        check("enc_k16_literal", subkey, 48'hCB3D8B0E17F5);
        check("enc_k16_idx", subkey_idx, 5'd16);
        check("enc_k16_last", subkey_last, 1'b1);
      end
      cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    end
    cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // Decrypt order on the same key
    cycle(1'b1, KEY_A, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        check("dec_first_literal", subkey, 48'hCB3D8B0E17F5);
        check("dec_first_idx", subkey_idx, 5'd16);
      end
      if (i == 15) begin
        check("dec_final_literal", subkey, 48'h1B02EFFC7072);
        check("dec_final_idx", subkey_idx, 5'd1);
        check("dec_final_last", subkey_last, 1'b1);
      end
      cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    end

    // key_valid held high: back-to-back keys with exactly one IDLE cycle between
    cycle(1'b1, 64'h0123456789ABCDEF, 1'b0, 1'b1, 1'b0);
    repeat (16) cycle(1'b1, 64'hFEDCBA9876543210, 1'b1, 1'b1, 1'b0);
    repeat (16) cycle(1'b1, 64'hA5A5A5A5_5A5A5A5A, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    repeat (16) cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);

    // Abort while presenting round 7, then abort in IDLE alongside a new key
    cycle(1'b1, 64'h0E329232EA6D0D73, 1'b0, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    check("abort7_idx", subkey_idx, 5'd7);
    cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 64'h3B3898371520F75E, 1'b1, 1'b1, 1'b1);
    repeat (15) cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    check("abort16_last", subkey_last, 1'b1);
    cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, KEY_A, 1'b0, 1'b1, 1'b0);
    check("post_abort_k1", subkey, 48'h1B02EFFC7072);
    repeat (16) cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);

    // Random ready, random keys and modes, junk on key inputs during RUN
    for (int k = 0; k < 100; k++) begin
      rk = {$urandom, $urandom};
      cycle(1'b1, rk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      guard = 0;
      while (sb.size() != 0 && guard < 200) begin
        cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);
        guard++;
      end
      check("drain_budget", 64'(sb.size()), 64'd0);
    end

    // Asynchronous reset while presenting round 9
    cycle(1'b1, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b1, 1'b0);
    repeat (8) cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    check("pre_reset_idx", subkey_idx, 5'd9);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_key_ready", key_ready, 1'b1);
    check("mid_rst_subkey_valid", subkey_valid, 1'b0);
    check("mid_rst_subkey", subkey, 48'h0);
    check("mid_rst_subkey_idx", subkey_idx, 5'd0);
    check("mid_rst_subkey_last", subkey_last, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 64'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      check("zero_key_subkey", subkey, 48'h0);
      cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    end
    cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
